fetch: RTL



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_if_id_reg.sv | 37 +++
 rtl/fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// pipeline register.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  localparam int PC_STEP = 4;
  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 21;
  localparam logic [INSTR_W-1:0] BUBBLE = 32'h0;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus: single outstanding request,
// address held stable until the one-cycle ack.
interface fetch_if #(
  parameter int N = 64
);

  logic                          imem_req;
  logic [N-1:0]                  imem_addr;
  logic                          imem_ack;
  logic [fetch_pkg::INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_if_id_reg.sv
// Pipeline register for {instr, pc, valid} with load enable and flush;
// flush wins over enable and inserts a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [N-1:0]       pc,
  input  logic               valid,
  output logic [INSTR_W-1:0] instr_q,
  output logic [N-1:0]       pc_q,
  output logic               valid_q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= BUBBLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q <= instr;
      pc_q    <= pc;
      valid_q <= valid;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, variable-latency memory requests, one-entry
// stall buffer, in-flight redirect handling, and the IF/ID register.
module fetch
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_d,
  input  logic                     PCSrc,
  input  logic [N-1:0]             PCBranch,
  fetch_if.master                  imem,
  output logic [INSTR_W-1:0]       instr_d,
  output logic [N-1:0]             pc_d,
  output logic [OP_MSB-OP_LSB:0]   op_d,
  output logic                     valid_d
);

  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  state_t               state, state_n;
  logic [N-1:0]         pc_f, pc_n, pc_next, target;
  logic [N-1:0]         redir_tgt, redir_tgt_n;
  logic                 redir_pend, redir_pend_n;
  logic [INSTR_W-1:0]   buf_instr, buf_instr_n;
  logic [N-1:0]         buf_pc, buf_pc_n;
  logic                 buf_valid, buf_valid_n;
  logic                 req;
  logic                 ifid_en, ifid_flush, ifid_valid;
  logic [INSTR_W-1:0]   ifid_instr;
  logic [N-1:0]         ifid_pc;

  assign target         = PCBranch & ALIGN_MASK;
  assign pc_next        = pc_f + N'(PC_STEP);
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BOOT;
      pc_f       <= PC_RESET;
      buf_valid  <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      buf_valid  <= buf_valid_n;
      redir_pend <= redir_pend_n;
    end
  end

  // NOTE: payload registers are qualified by buf_valid / redir_pend, so they
  // are deliberately left without reset.
  always_ff @(posedge clk) begin
    buf_instr <= buf_instr_n;
    buf_pc    <= buf_pc_n;
    redir_tgt <= redir_tgt_n;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    pc_n         = pc_f;
    buf_instr_n  = buf_instr;
    buf_pc_n     = buf_pc;
    buf_valid_n  = buf_valid;
    redir_tgt_n  = redir_tgt;
    redir_pend_n = redir_pend;
    req          = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem.imem_rdata;
    ifid_pc      = pc_f;
    ifid_valid   = 1'b1;

    case (state)
      S_BOOT: begin
        state_n = S_REQ;
        if (PCSrc) begin
          ifid_flush = 1'b1;
          pc_n       = target;
        end
      end

      S_REQ: begin
        req = 1'b1;
        if (PCSrc) begin
          ifid_flush  = 1'b1;
          buf_valid_n = 1'b0;
          if (imem.imem_ack) begin
            pc_n = target;
          end else begin
            // Request still in flight: it must complete before the new fetch.
            redir_tgt_n  = target;
            redir_pend_n = 1'b1;
            state_n      = S_DROP;
          end
        end else if (imem.imem_ack) begin
          if (!stall_d) begin
            ifid_en = 1'b1;
            pc_n    = pc_next;
          end else begin
            buf_instr_n = imem.imem_rdata;
            buf_pc_n    = pc_f;
            buf_valid_n = 1'b1;
            state_n     = S_HOLD;
          end
        end else if (!stall_d) begin
          ifid_flush = 1'b1;
        end
      end

      S_HOLD: begin
        if (PCSrc) begin
          ifid_flush  = 1'b1;
          buf_valid_n = 1'b0;
          pc_n        = target;
          state_n     = S_REQ;
        end else if (!stall_d) begin
          ifid_en     = 1'b1;
          ifid_instr  = buf_instr;
          ifid_pc     = buf_pc;
          ifid_valid  = buf_valid;
          buf_valid_n = 1'b0;
          pc_n        = pc_next;
          state_n     = S_REQ;
        end
      end

      S_DROP: begin
        req = 1'b1;
        if (PCSrc) begin
          ifid_flush  = 1'b1;
          redir_tgt_n = target;
        end
        if (imem.imem_ack && redir_pend) begin
          pc_n         = PCSrc ? target : redir_tgt;
          redir_pend_n = 1'b0;
          state_n      = S_REQ;
        end
      end

      default: state_n = S_BOOT;
    endcase
  end

  if_id_reg #(.N(N)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .en      (ifid_en),
    .flush   (ifid_flush),
    .instr   (ifid_instr),
    .pc      (ifid_pc),
    .valid   (ifid_valid),
    .instr_q (instr_d),
    .pc_q    (pc_d),
    .valid_q (valid_d)
  );

  assign op_d = instr_d[OP_MSB:OP_LSB];

endmodule
